add_seq_arb: RTL and testbench
==============================

Name: add_seq_arb

Overview:
- Shares one 16-bit slice adder between two requesters.
- Sequences wide additions of 16*WORDS bits one 16-bit slice per cycle, least-significant slice first, with a registered carry between slices.
- Sits in the data pipeline in front of consumers that need adds wider than 16 bits.
- Uses valid/ready handshakes on both requester ports and on the single response port.

Parameters:
- WORDS, 4, number of 16-bit slices per operand; legal range 2..8; operand width W = 16*WORDS.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_ready  out  1  requester 0 accepted on this edge when valid&ready.
- req0_a  in  W  requester 0 operand a.
- req0_b  in  W  requester 0 operand b.
- req1_valid  in  1  requester 1 has an operand pair.
- req1_ready  out  1  requester 1 handshake ready.
- req1_a  in  W  requester 1 operand a.
- req1_b  in  W  requester 1 operand b.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result when valid&ready.
- rsp_sum  out  W  a+b modulo 2^W.
- rsp_carry  out  1  carry out of the top slice.
- rsp_id  out  1  requester that owns the result.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - FSM=IDLE, rr_ptr=0, slice index k=0, carry register=0.
  - rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, busy=0.
  - req*_ready=0 while reset is asserted.
- Reset mid-operation discards the in-flight operation. No response is issued for it.
- FSM IDLE:
  - grant0 = req0_valid & (rr_ptr==0 | !req1_valid).
  - grant1 = req1_valid & (rr_ptr==1 | !req0_valid).
  - reqX_ready = (state==IDLE) & grantX. This is combinational and at most one is high.
  - On a handshake: latch a, b and id; set rr_ptr = ~id; clear carry and k; go to RUN.
- FSM RUN, each cycle:
  - {c, s} = a[k] + b[k] + carry, computed on 17 bits.
  - sum slice k <= s; carry <= c; k <= k+1.
  - After slice WORDS-1: rsp_carry <= c, go to DONE.
- FSM DONE:
  - rsp_valid=1. rsp_sum, rsp_carry and rsp_id are held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE. rsp_valid drops on the same edge.
- Latency: rsp_valid rises exactly WORDS edges after the accepting edge. Throughput is one operation per WORDS+2 cycles with rsp_ready held high.
- No request is accepted outside IDLE. reqX_valid may toggle freely while the block is not ready.
- Both valid in IDLE: grant goes to rr_ptr. Strict alternation holds under continuous contention.
- A single requester may be granted back-to-back when the other is idle.
- Carry-out wrap-around: sum wraps modulo 2^W and rsp_carry=1.

Optional Feature:
- Macro: ADD_SEQ_SAT_EN.
- Defined: when the final carry is 1, rsp_sum is forced to all ones. rsp_carry still reports 1.
- Undefined: rsp_sum is modular, as above. No extra logic is generated.

Decomposition:
- Shared package add_seq_pkg holds:
  - state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - SLICE_W=16;
  - the requester-id constants.
- Natural sub-module add_slice16: combinational 16-bit adder with carry-in, giving sum[15:0] and cout. The controller owns all registers.

Test Plan (WORDS=4 unless stated):
- req0 a=0x0000_0000_0000_FFFF, b=0x1 -> rsp_sum=0x0000_0000_0001_0000, carry=0, id=0; rsp_valid exactly 4 edges after accept.
- req1 a=0xFFFF_FFFF_FFFF_FFFF, b=0x1 -> sum=0 and carry=1. With ADD_SEQ_SAT_EN: sum=0xFFFF_FFFF_FFFF_FFFF, carry=1.
- Both valid continuously, rsp_ready=1 -> grant order 0,1,0,1. req0 only for 2 ops -> two consecutive grants to id 0.
- rsp_ready low for 5 cycles in DONE -> rsp_* stable, req*_ready stay 0, then a single handshake and return to IDLE.
- rst_n low during RUN slice 2 -> outputs at reset values immediately, no response. After release, a new req0 (a=0x1234, b=0x4321) -> sum=0x5555.
- WORDS=2, a=0x0001_FFFF, b=0x0000_0001 -> sum=0x0002_0000, carry=0; carry propagates across the slice boundary.

Source files
------------

// File: rtl/add_seq_pkg.sv
// Shared types and constants for the sequenced wide adder with two-port arbitration.
package add_seq_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 16;

  localparam logic ID0 = 1'b0;
  localparam logic ID1 = 1'b1;
endpackage

// File: rtl/add_seq_arb_if.sv
// Requester and response handshake bundle for add_seq_arb.
// Handshake rule: a transfer happens on a rising edge where valid and ready are both high;
// valid must not depend on ready, payload is stable while valid is high and ready low.
interface add_seq_arb_if #(
    parameter int WORDS = 4
);
    localparam int W = 16 * WORDS;

    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_sum;
    logic         rsp_carry;
    logic         rsp_id;

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id
    );
endinterface

// File: rtl/add_slice16.sv
// Combinational 16-bit slice adder with carry-in; no state.
module add_slice16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'b0, cin};
endmodule

// File: rtl/add_seq_arb.sv
// Round-robin shared 16-bit slice adder that sequences 16*WORDS-bit additions LSB slice first.
// Optional macro ADD_SEQ_SAT_EN saturates rsp_sum to all ones when the final carry is set.
module add_seq_arb
    import add_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    add_seq_arb_if.slave bus,
    output logic         busy,
    output state_t       dbg_state
);
    localparam int W  = SLICE_W * WORDS;
    localparam int KW = $clog2(WORDS);

    state_t                state;
    logic                  rr_ptr;
    logic [KW-1:0]         k;
    logic                  carry;
    logic [W-1:0]          a_q;
    logic [W-1:0]          b_q;
    logic [W-1:0]          sum_q;
    logic                  rsp_valid_q;
    logic                  rsp_carry_q;
    logic                  rsp_id_q;
    logic                  busy_q;

    logic                  grant0;
    logic                  grant1;
    logic                  idle_ok;
    logic                  last;
    logic [SLICE_W-1:0]    a_sl;
    logic [SLICE_W-1:0]    b_sl;
    logic [SLICE_W-1:0]    s_sl;
    logic                  c_sl;

    // Ties go to rr_ptr; a lone requester wins regardless of the pointer.
    assign grant0  = bus.req0_valid & ((rr_ptr == ID0) | !bus.req1_valid);
    assign grant1  = bus.req1_valid & ((rr_ptr == ID1) | !bus.req0_valid);
    assign idle_ok = rst_n & (state == IDLE);

    assign bus.req0_ready = idle_ok & grant0;
    assign bus.req1_ready = idle_ok & grant1;

    assign last = (k == KW'(WORDS - 1));

    always_comb begin
        a_sl = a_q[int'(k)*SLICE_W +: SLICE_W];
        b_sl = b_q[int'(k)*SLICE_W +: SLICE_W];
    end

    add_slice16 u_slice (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry),
        .sum  (s_sl),
        .cout (c_sl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= ID0;
            k           <= '0;
            carry       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_carry_q <= 1'b0;
            rsp_id_q    <= ID0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req0_ready | bus.req1_ready) begin
                        a_q      <= bus.req1_ready ? bus.req1_a : bus.req0_a;
                        b_q      <= bus.req1_ready ? bus.req1_b : bus.req0_b;
                        rsp_id_q <= bus.req1_ready;
                        rr_ptr   <= ~bus.req1_ready;
                        carry    <= 1'b0;
                        k        <= '0;
                        busy_q   <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum_q[int'(k)*SLICE_W +: SLICE_W] <= s_sl;
                    carry <= c_sl;
                    k     <= k + 1'b1;
                    if (last) begin
                        rsp_carry_q <= c_sl;
`ifdef ADD_SEQ_SAT_EN
                        if (c_sl) sum_q <= '1;
`endif
                        k           <= '0;
                        rsp_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_carry = rsp_carry_q;
    assign bus.rsp_id    = rsp_id_q;
    assign busy          = busy_q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_add_seq_arb.sv
// Directed scoreboard bench for add_seq_arb (WORDS=4 main instance, WORDS=2 side instance).
module tb_add_seq_arb;
  import add_seq_pkg::*;

  localparam int W  = 64;
  localparam int W2 = 32;

  logic clk;
  logic rst_n;
  logic busy;
  logic busy2;
  state_t dbg_state;
  state_t dbg_state2;

  int n_checks = 0;
  int n_errors = 0;

  logic [W+1:0]  exp_q[$];
  logic [W2+1:0] exp2_q[$];
  logic          grant_log[$];
  logic [W+1:0]  e;
  logic [W2+1:0] e2;

  add_seq_arb_if #(.WORDS(4)) bus ();
  add_seq_arb_if #(.WORDS(2)) bus2 ();

  add_seq_arb #(.WORDS(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  add_seq_arb #(.WORDS(2)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus2),
    .busy      (busy2),
    .dbg_state (dbg_state2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: present operands, wait for the grant, push expectation at the handshake
  task automatic send(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] exp_sum, input logic exp_carry,
                      input bit push, input bit hold);
    int  n;
    logic rdy;
    @(negedge clk);
    if (id == 0) begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
    end
    #1;
    n = 0;
    rdy = (id == 0) ? bus.req0_ready : bus.req1_ready;
    while (!rdy && n < 200) begin
      @(negedge clk); #1;
      n++;
      rdy = (id == 0) ? bus.req0_ready : bus.req1_ready;
    end
    if (!rdy) begin
      n_checks++; n_errors++;
      $display("FAIL send_timeout: requester %0d got no ready within 200 cycles", id);
    end else begin
      if (push) exp_q.push_back({id[0], exp_carry, exp_sum});
      grant_log.push_back(id[0]);
      @(posedge clk);
    end
    #1;
    if (!hold) begin
      if (id == 0) bus.req0_valid = 1'b0;
      else         bus.req1_valid = 1'b0;
    end
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL rsp_unexpected: got id %0d sum %h, required no response", bus.rsp_id, bus.rsp_sum);
      end else begin
        e = exp_q.pop_front();
        check("rsp_sum",   128'(bus.rsp_sum),   128'(e[W-1:0]));
        check("rsp_carry", 128'(bus.rsp_carry), 128'(e[W]));
        check("rsp_id",    128'(bus.rsp_id),    128'(e[W+1]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus2.rsp_valid && bus2.rsp_ready) begin
      if (exp2_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL rsp2_unexpected: got sum %h, required no response", bus2.rsp_sum);
      end else begin
        e2 = exp2_q.pop_front();
        check("w2_rsp_sum",   128'(bus2.rsp_sum),   128'(e2[W2-1:0]));
        check("w2_rsp_carry", 128'(bus2.rsp_carry), 128'(e2[W2]));
        check("w2_rsp_id",    128'(bus2.rsp_id),    128'(e2[W2+1]));
      end
    end
  end

  initial begin
    int n;
    logic [W-1:0] all_ones;
    logic [W-1:0] t2_sum;
    all_ones = '1;
`ifdef ADD_SEQ_SAT_EN
    t2_sum = all_ones;
`else
    t2_sum = '0;
`endif

    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready = 1'b1;
    bus2.req0_valid = 1'b0; bus2.req1_valid = 1'b0;
    bus2.req0_a = '0; bus2.req0_b = '0; bus2.req1_a = '0; bus2.req1_b = '0;
    bus2.rsp_ready = 1'b1;

    // reset state, with requests asserted during reset
    rst_n = 1'b0;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_req0_ready", 128'(bus.req0_ready), 128'(0));
    check("reset_req1_ready", 128'(bus.req1_ready), 128'(0));
    check("reset_rsp_valid",  128'(bus.rsp_valid),  128'(0));
    check("reset_rsp_sum",    128'(bus.rsp_sum),    128'(0));
    check("reset_rsp_carry",  128'(bus.rsp_carry),  128'(0));
    check("reset_rsp_id",     128'(bus.rsp_id),     128'(0));
    check("reset_busy",       128'(busy),           128'(0));
    check("reset_state",      128'(dbg_state),      128'(IDLE));
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // carry across slice 0 -> 1, with exact latency
    send(0, 64'h0000_0000_0000_FFFF, 64'h1, 64'h0000_0000_0001_0000, 1'b0, 1, 0);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("latency_edge%0d", i), 128'(bus.rsp_valid), 128'(i == 4));
    end
    check("busy_in_done", 128'(busy), 128'(1));

    // full wrap-around on requester 1
    send(1, all_ones, 64'h1, t2_sum, 1'b1, 1, 0);

    // continuous contention: 0,1,0,1
    grant_log.delete();
    fork
      begin
        send(0, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h0000_0001_0000_0000, 1'b0, 1, 1);
        send(0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1, 1);
      end
      begin
        send(1, 64'h1111_2222_3333_4444, 64'h1111_1111_1111_1111, 64'h2222_3333_4444_5555, 1'b0, 1, 1);
        send(1, 64'h0000_8000_8000_8000, 64'h0000_8000_8000_8000, 64'h0001_0001_0001_0000, 1'b0, 1, 0);
      end
    join
    bus.req0_valid = 1'b0;
    check("contend_count", 128'(grant_log.size()), 128'(4));
    if (grant_log.size() == 4) begin
      check("contend_g0", 128'(grant_log[0]), 128'(0));
      check("contend_g1", 128'(grant_log[1]), 128'(1));
      check("contend_g2", 128'(grant_log[2]), 128'(0));
      check("contend_g3", 128'(grant_log[3]), 128'(1));
    end

    // lone requester granted back to back
    grant_log.delete();
    send(0, 64'h2, 64'h3, 64'h5, 1'b0, 1, 1);
    send(0, 64'hABCD_0000_0000_0000, 64'h1111_0000_0000_0000, 64'hBCDE_0000_0000_0000, 1'b0, 1, 0);
    check("solo_count", 128'(grant_log.size()), 128'(2));
    if (grant_log.size() == 2) begin
      check("solo_g0", 128'(grant_log[0]), 128'(0));
      check("solo_g1", 128'(grant_log[1]), 128'(0));
    end

    // consumer stall in DONE
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    send(1, 64'h0123_4567_89AB_CDEF, 64'h1000_0000_0000_0001, 64'h1123_4567_89AB_CDF0, 1'b0, 1, 0);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin @(negedge clk); n++; end
    check("stall_reached_done", 128'(bus.rsp_valid), 128'(1));
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("stall_valid",      128'(bus.rsp_valid),  128'(1));
      check("stall_sum",        128'(bus.rsp_sum),    128'(64'h1123_4567_89AB_CDF0));
      check("stall_carry",      128'(bus.rsp_carry),  128'(0));
      check("stall_id",         128'(bus.rsp_id),     128'(1));
      check("stall_req0_ready", 128'(bus.req0_ready), 128'(0));
      check("stall_req1_ready", 128'(bus.req1_ready), 128'(0));
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release_valid", 128'(bus.rsp_valid), 128'(0));
    check("stall_release_state", 128'(dbg_state),     128'(IDLE));
    check("stall_release_busy",  128'(busy),          128'(0));

    // reset during RUN slice 2 drops the operation
    send(0, 64'h5, 64'h6, 64'hB, 1'b0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
    check("midrst_rsp_sum",   128'(bus.rsp_sum),   128'(0));
    check("midrst_busy",      128'(busy),          128'(0));
    check("midrst_state",     128'(dbg_state),     128'(IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_rsp", 128'(bus.rsp_valid), 128'(0));
    end
    send(0, 64'h1234, 64'h4321, 64'h5555, 1'b0, 1, 0);

    // WORDS=2 instance: carry crosses the single slice boundary
    @(negedge clk);
    bus2.req0_a = 32'h0001_FFFF; bus2.req0_b = 32'h0000_0001; bus2.req0_valid = 1'b1;
    #1;
    n = 0;
    while (!bus2.req0_ready && n < 50) begin @(negedge clk); #1; n++; end
    check("w2_accept", 128'(bus2.req0_ready), 128'(1));
    if (bus2.req0_ready) exp2_q.push_back({1'b0, 1'b0, 32'h0002_0000});
    @(posedge clk); #1;
    bus2.req0_valid = 1'b0;

    // drain
    n = 0;
    while ((exp_q.size() != 0 || exp2_q.size() != 0) && n < 200) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    check("drain_exp_q",  128'(exp_q.size()),  128'(0));
    check("drain_exp2_q", 128'(exp2_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
